// File: rtl/lf_pkg.sv
// Shared definitions for the LF capture path: FSM encoding, decimation limits
// and default comparator thresholds.
package lf_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } lf_state_e;

  localparam int unsigned DECIM_MAX     = 3;
  localparam logic [7:0]  THRESH_HI_DEF = 8'd140;
  localparam logic [7:0]  THRESH_LO_DEF = 8'd110;
  localparam logic [7:0]  MIN_DIVISOR   = 8'd2;

  // Counter value of the last sample in a box-car group of 2^decim samples.
  function automatic logic [DECIM_MAX-1:0] group_last(input logic [1:0] decim);
    return DECIM_MAX'((4'd1 << decim) - 4'd1);
  endfunction

endpackage

// File: rtl/lf_sample_fifo2.sv
// Two-entry valid/ready FIFO for 8-bit LF samples. A push into a full FIFO is
// accepted only if the head is popped in the same cycle; otherwise it is dropped.
module lf_sample_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       full,
  output logic       push_drop
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       pop, do_push;

  assign valid     = (count_q != 2'd0);
  assign full      = (count_q == 2'd2);
  assign pop       = valid & ready;
  assign do_push   = push & (~full | pop);
  assign push_drop = push & full & ~pop;
  assign data      = mem_q[rd_ptr_q];

  // When full with a pop, wr_ptr equals rd_ptr: the new entry replaces the head leaving now.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= 8'd0;
      mem_q[1] <= 8'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/lf_adc_sampler.sv
// LF ADC sampler: derives adc_clk and the sample strobe from the divider count,
// box-car averages 2^decim captures and streams results through a 2-entry FIFO.
// Optional hysteresis comparator on edge_bit: define LF_ADC_SAMPLER_THRESH_EN.
module lf_adc_sampler
  import lf_pkg::*;
#(
  parameter int unsigned ACC_W     = 11,
  parameter logic [7:0]  THRESH_HI = THRESH_HI_DEF,
  parameter logic [7:0]  THRESH_LO = THRESH_LO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] divisor,
  input  logic [7:0] div_cnt,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] decim,
  input  logic [7:0] adc_d,
  output logic       adc_clk,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overflow,
  output logic       cfg_err,
  output logic       running,
  output logic       edge_bit
);

  lf_state_e            state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [1:0]           decim_q, decim_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 overflow_q, overflow_d;
  logic                 adc_clk_q, adc_clk_d;
  logic                 start_ok;
  logic [7:0]           samp_q;
  logic                 samp_vld_q;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic [DECIM_MAX-1:0] cnt_q, cnt_d;
  logic                 strobe, acc_en, res_push;
  logic [7:0]           res_data;
  logic                 fifo_full, fifo_drop;

  // Run control; stop has priority over start in every state.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    decim_d   = decim_q;
    cfg_err_d = cfg_err_q;
    start_ok  = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            start_ok  = 1'b1;
            div_d     = divisor;
            decim_d   = decim;
            cfg_err_d = (divisor < MIN_DIVISOR);
            state_d   = (divisor < MIN_DIVISOR) ? StIdle : StArm;
          end
        end
        StArm: begin
          if (div_cnt == 8'd0) state_d = StRun;
        end
        StRun: begin
          state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign overflow_d = start_ok ? 1'b0 : (overflow_q | (fifo_drop & fifo_full));
  assign adc_clk_d  = (state_d != StIdle) && (div_cnt <= (div_d >> 1));

  assign strobe   = (state_q == StRun) && !stop && (div_cnt == div_q);
  // An add coinciding with stop belongs to a group that is being discarded.
  assign acc_en   = samp_vld_q && (state_q == StRun) && !stop;
  assign acc_sum  = acc_q + ACC_W'(samp_q);
  assign res_push = acc_en && (cnt_q == group_last(decim_q));
  assign res_data = 8'(acc_sum >> decim_q);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_d == StIdle) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_en) begin
      if (res_push) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= 8'd0;
      decim_q    <= 2'd0;
      cfg_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      adc_clk_q  <= 1'b0;
      samp_q     <= 8'd0;
      samp_vld_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      decim_q    <= decim_d;
      cfg_err_q  <= cfg_err_d;
      overflow_q <= overflow_d;
      adc_clk_q  <= adc_clk_d;
      samp_vld_q <= strobe;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      if (strobe) samp_q <= adc_d;
    end
  end

  lf_sample_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data (res_data),
    .ready     (sample_ready),
    .valid     (sample_valid),
    .data      (sample_data),
    .full      (fifo_full),
    .push_drop (fifo_drop)
  );

`ifdef LF_ADC_SAMPLER_THRESH_EN
  logic edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= 1'b0;
    end else if (state_d == StIdle) begin
      edge_q <= 1'b0;
    end else if (strobe) begin
      if (adc_d >= THRESH_HI) edge_q <= 1'b1;
      else if (adc_d <= THRESH_LO) edge_q <= 1'b0;
    end
  end

  assign edge_bit = edge_q;
`else
  assign edge_bit = 1'b0;
`endif

  assign adc_clk  = adc_clk_q;
  assign overflow = overflow_q;
  assign cfg_err  = cfg_err_q;
  assign running  = (state_q != StIdle);

endmodule

// File: tb/tb_lf_adc_sampler.sv
// Self-checking bench for lf_adc_sampler: randomized stimulus against a
// queue-based reference model of the run/average/FIFO behaviour.
module tb_lf_adc_sampler;

  localparam int T_HI = 140;
  localparam int T_LO = 110;

  logic       clk = 1'b0;
  logic       rst, start, stop, sample_ready;
  logic [7:0] divisor, div_cnt, adc_d;
  logic [1:0] decim;
  logic       adc_clk, sample_valid, overflow, cfg_err, running, edge_bit;
  logic [7:0] sample_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lf_adc_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .divisor      (divisor),
    .div_cnt      (div_cnt),
    .start        (start),
    .stop         (stop),
    .decim        (decim),
    .adc_d        (adc_d),
    .adc_clk      (adc_clk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .cfg_err      (cfg_err),
    .running      (running),
    .edge_bit     (edge_bit)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per clock edge from the presented inputs.
  bit m_active, m_run, m_cap_vld, m_ovf, m_cfg, m_adc, m_edge, m_capt_now;
  int m_div, m_decim, m_sum, m_n, m_cap, m_strobes, m_prev_cnt;
  int m_fifo[$];
  int m_caps[$];

  task automatic model_edge();
    bit pop, push, nact, nrun;
    int res;
    m_capt_now = 0;
    if (rst) begin
      m_active = 0; m_run = 0; m_cap_vld = 0; m_ovf = 0; m_cfg = 0; m_adc = 0; m_edge = 0;
      m_sum = 0; m_n = 0; m_div = 0; m_decim = 0;
      m_fifo.delete();
      return;
    end
    pop  = (m_fifo.size() > 0) && sample_ready;
    push = 0;
    res  = 0;
    if (m_cap_vld && !stop) begin
      m_sum += m_cap;
      m_n++;
      if (m_n == (1 << m_decim)) begin
        push  = 1;
        res   = m_sum / (1 << m_decim);
        m_sum = 0;
        m_n   = 0;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < 2) m_fifo.push_back(res);
      else m_ovf = 1;
    end
    m_cap_vld = 0;
    if (m_run && !stop && int'(div_cnt) == m_div) begin
      m_cap_vld  = 1;
      m_cap      = int'(adc_d);
      m_capt_now = 1;
      m_strobes++;
      m_caps.push_back(int'(adc_d));
`ifdef LF_ADC_SAMPLER_THRESH_EN
      if (int'(adc_d) >= T_HI) m_edge = 1;
      else if (int'(adc_d) <= T_LO) m_edge = 0;
`endif
    end
    nact = m_active;
    nrun = m_run;
    if (stop) begin
      nact = 0;
      nrun = 0;
    end else if (!m_active && start) begin
      m_div   = int'(divisor);
      m_decim = int'(decim);
      m_ovf   = 0;
      m_cfg   = (divisor < 8'd2);
      nact    = (divisor >= 8'd2);
    end else if (m_active && !m_run && div_cnt == 8'd0) begin
      nrun = 1;
    end
    m_active = nact;
    m_run    = nrun;
    if (!m_active) begin
      m_sum = 0; m_n = 0; m_cap_vld = 0; m_edge = 0;
    end
    m_adc = m_active && (int'(div_cnt) <= (m_div >> 1));
  endtask

  // One clock: model consumes the presented inputs, then the divider advances.
  task automatic step();
    model_edge();
    m_prev_cnt = int'(div_cnt);
    @(posedge clk);
    #1;
    cyc++;
    start   = 1'b0;
    stop    = 1'b0;
    div_cnt = (div_cnt >= divisor) ? 8'd0 : div_cnt + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; divisor = 8'd9; decim = 2'd2;
    adc_d = 8'hA5; sample_ready = 1'b1; div_cnt = 8'd0;
    step();
    start = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (adc_clk !== 1'b0) begin errors++; $display("FAIL reset_adc_clk got=%b exp=0", adc_clk); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (sample_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", sample_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (edge_bit !== 1'b0) begin errors++; $display("FAIL reset_edge_bit got=%b exp=0", edge_bit); end
    rst = 1'b0;
  endtask

  task automatic test_constant();
    int s4, nres, last, first, guard;
    divisor = 8'd9; decim = 2'd2; adc_d = 8'd100; sample_ready = 1'b1;
    guard = 0;
    while (div_cnt != 8'd3 && guard < 20) begin step(); guard++; end
    m_strobes = 0; s4 = -1; nres = 0; last = -1; first = -1;
    start = 1'b1;
    step();
    repeat (180) begin
      step();
      if (m_capt_now && m_strobes == 4) s4 = cyc - 1;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL const_running got=%b exp=1", running); end
      checks++;
      if (adc_clk !== (m_prev_cnt <= 4)) begin
        errors++; $display("FAIL const_adc_clk cnt=%0d got=%b exp=%b", m_prev_cnt, adc_clk, m_prev_cnt <= 4);
      end
      checks++;
      if (sample_valid !== (m_fifo.size() > 0)) begin
        errors++; $display("FAIL const_valid cyc=%0d got=%b exp=%b", cyc, sample_valid, m_fifo.size() > 0);
      end
      if (sample_valid === 1'b1) begin
        checks++; if (sample_data !== 8'd100) begin errors++; $display("FAIL const_data got=%0d exp=100", sample_data); end
        if (first < 0) first = cyc;
        if (last >= 0) begin
          checks++; if (cyc - last != 40) begin errors++; $display("FAIL const_period got=%0d exp=40", cyc - last); end
        end
        last = cyc;
        nres++;
      end
    end
    checks++; if (first != s4 + 2) begin errors++; $display("FAIL const_latency got=%0d exp=%0d", first, s4 + 2); end
    checks++; if (nres != 4) begin errors++; $display("FAIL const_count got=%0d exp=4", nres); end
    stop = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL const_stop_running got=%b exp=0", running); end
    checks++; if (adc_clk !== 1'b0) begin errors++; $display("FAIL const_stop_adc_clk got=%b exp=0", adc_clk); end
  endtask

  task automatic test_ramp();
    int prev, nres;
    for (int pass = 0; pass < 2; pass++) begin
      divisor = 8'($urandom_range(2, 7)); decim = (pass == 0) ? 2'd1 : 2'd0;
      sample_ready = 1'b1; adc_d = 8'd10; prev = -1; nres = 0;
      start = 1'b1;
      step();
      repeat (12 * (int'(divisor) + 1) + 8) begin
        if (div_cnt == 8'd0) adc_d = (adc_d == 8'd10) ? 8'd20 : 8'd10;
        step();
        checks++;
        if (sample_valid !== (m_fifo.size() > 0)) begin
          errors++; $display("FAIL ramp_valid got=%b exp=%b", sample_valid, m_fifo.size() > 0);
        end
        if (sample_valid === 1'b1 && m_fifo.size() > 0) begin
          nres++;
          checks++;
          if (sample_data !== 8'(m_fifo[0])) begin
            errors++; $display("FAIL ramp_model got=%0d exp=%0d", sample_data, m_fifo[0]);
          end
          if (pass == 0) begin
            checks++; if (sample_data !== 8'd15) begin errors++; $display("FAIL ramp_avg got=%0d exp=15", sample_data); end
          end else begin
            checks++;
            if ((sample_data != 8'd10 && sample_data != 8'd20) || int'(sample_data) == prev) begin
              errors++; $display("FAIL ramp_alternate got=%0d prev=%0d exp=other of 10/20", sample_data, prev);
            end
            prev = int'(sample_data);
          end
        end
      end
      checks++; if (nres < 4) begin errors++; $display("FAIL ramp_count got=%0d exp>=4", nres); end
      stop = 1'b1;
      step();
    end
  endtask

  task automatic test_backpressure();
    int guard, k;
    divisor = 8'd2; decim = 2'd0; sample_ready = 1'b0;
    m_strobes = 0; m_caps.delete(); guard = 0;
    start = 1'b1;
    step();
    while (m_strobes < 3 && guard < 50) begin adc_d = 8'($urandom); step(); guard++; end
    checks++; if (guard >= 50) begin errors++; $display("FAIL bp_timeout got=%0d strobes exp=3", m_strobes); end
    adc_d = 8'($urandom);
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", sample_valid); end
    stop = 1'b1;
    step();
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL bp_stop got=%b exp=0", running); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got=%b exp=1", overflow); end
    checks++; if (sample_data !== 8'(m_caps[0])) begin errors++; $display("FAIL bp_hold got=%0d exp=%0d", sample_data, m_caps[0]); end
    sample_ready = 1'b1;
    k = 0;
    repeat (5) begin
      if (sample_valid === 1'b1) begin
        checks++;
        if (k > 1 || sample_data !== 8'(m_caps[k])) begin
          errors++; $display("FAIL bp_drain k=%0d got=%0d exp=%0d", k, sample_data, (k < 2) ? m_caps[k] : -1);
        end
        k++;
      end
      step();
    end
    checks++; if (k != 2) begin errors++; $display("FAIL bp_drain_count got=%0d exp=2", k); end
  endtask

  task automatic test_stop_mid_group();
    int guard;
    divisor = 8'($urandom_range(3, 8)); decim = 2'd3; sample_ready = 1'b1;
    m_strobes = 0; guard = 0;
    start = 1'b1;
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL smg_ovf_clear got=%b exp=0", overflow); end
    while (m_strobes < 5 && guard < 100) begin
      adc_d = 8'($urandom);
      step();
      guard++;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL smg_early_valid got=%b exp=0", sample_valid); end
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL smg_timeout got=%0d strobes exp=5", m_strobes); end
    stop = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL smg_running got=%b exp=0", running); end
    checks++; if (adc_clk !== 1'b0) begin errors++; $display("FAIL smg_adc_clk got=%b exp=0", adc_clk); end
    repeat (40) begin
      step();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL smg_no_result got=%b exp=0", sample_valid); end
    end
  endtask

  task automatic test_cfg_err();
    for (int d = 0; d < 2; d++) begin
      divisor = 8'(d);
      start = 1'b1;
      step();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_set div=%0d got=%b exp=1", d, cfg_err); end
      repeat (10) begin
        step();
        checks++;
        if (running !== 1'b0 || adc_clk !== 1'b0 || sample_valid !== 1'b0) begin
          errors++; $display("FAIL cfg_idle run=%b adc_clk=%b valid=%b exp=0/0/0", running, adc_clk, sample_valid);
        end
      end
    end
    divisor = 8'd5; start = 1'b1; stop = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL cfg_startstop got=%b exp=0", running); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_startstop_keep got=%b exp=1", cfg_err); end
    start = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cfg_restart got=%b exp=1", running); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_clear got=%b exp=0", cfg_err); end
    stop = 1'b1;
    step();
  endtask

  task automatic test_random();
    int n;
    repeat (6) begin
      divisor = 8'($urandom_range(2, 10)); decim = 2'($urandom);
      start = 1'b1;
      step();
      n = $urandom_range(150, 400);
      for (int i = 0; i < n + 6; i++) begin
        adc_d = 8'($urandom);
        sample_ready = (i >= n) || ($urandom_range(0, 3) != 0);
        decim = 2'($urandom);
        if (i < n && $urandom_range(0, 60) == 0) start = 1'b1;
        if (i < n && $urandom_range(0, 200) == 0) stop = 1'b1;
        if (i == n) stop = 1'b1;
        step();
        checks++; if (running !== m_active) begin errors++; $display("FAIL rnd_running got=%b exp=%b", running, m_active); end
        checks++; if (adc_clk !== m_adc) begin errors++; $display("FAIL rnd_adc_clk got=%b exp=%b", adc_clk, m_adc); end
        checks++;
        if (sample_valid !== (m_fifo.size() > 0)) begin
          errors++; $display("FAIL rnd_valid got=%b exp=%b", sample_valid, m_fifo.size() > 0);
        end
        if (m_fifo.size() > 0) begin
          checks++;
          if (sample_data !== 8'(m_fifo[0])) begin
            errors++; $display("FAIL rnd_data got=%0d exp=%0d", sample_data, m_fifo[0]);
          end
        end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow got=%b exp=%b", overflow, m_ovf); end
        checks++; if (cfg_err !== m_cfg) begin errors++; $display("FAIL rnd_cfg_err got=%b exp=%b", cfg_err, m_cfg); end
        checks++; if (edge_bit !== m_edge) begin errors++; $display("FAIL rnd_edge_bit got=%b exp=%b", edge_bit, m_edge); end
      end
    end
  endtask

`ifdef LF_ADC_SAMPLER_THRESH_EN
  task automatic test_thresh();
    int seq[5] = '{100, 150, 120, 105, 130};
    bit exp_edge[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int guard;
    divisor = 8'd4; decim = 2'd0; sample_ready = 1'b1;
    m_strobes = 0; guard = 0;
    start = 1'b1;
    step();
    while (m_strobes < 5 && guard < 60) begin
      adc_d = 8'(seq[m_strobes]);
      step();
      guard++;
      if (m_capt_now) begin
        checks++;
        if (edge_bit !== exp_edge[m_strobes - 1]) begin
          errors++; $display("FAIL thresh_edge idx=%0d got=%b exp=%b", m_strobes - 1, edge_bit, exp_edge[m_strobes - 1]);
        end
      end
    end
    checks++; if (guard >= 60) begin errors++; $display("FAIL thresh_timeout got=%0d strobes exp=5", m_strobes); end
    stop = 1'b1;
    step();
    checks++; if (edge_bit !== 1'b0) begin errors++; $display("FAIL thresh_idle_clear got=%b exp=0", edge_bit); end
  endtask
`endif

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_backpressure();
    test_stop_mid_group();
    test_cfg_err();
`ifdef LF_ADC_SAMPLER_THRESH_EN
    test_thresh();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
